// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS pipeline trace capture block.
package mips_trace_pkg;

  localparam int STAMP_WIDTH    = 16;
  localparam int REC_WORD_WIDTH = 32;

  typedef enum logic [1:0] {
    REG_WB = 2'b00,
    MEM_WR = 2'b01
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e               kind;
    logic [REC_WORD_WIDTH-1:0] addr;
    logic [REC_WORD_WIDTH-1:0] data;
    logic [STAMP_WIDTH-1:0]    stamp;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo_dual_push.sv
// Circular trace buffer: up to two pushes and one pop per clock, show-ahead head.
module trace_fifo_dual_push
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push0_i,
  input  trace_rec_t    rec0_i,
  input  logic          push1_i,
  input  trace_rec_t    rec1_i,
  input  logic          pop_i,
  output trace_rec_t    head_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;
  logic [1:0]    n_push;

  // push1 is only ever raised together with push0, so it lands in the slot after it
  assign do_pop = pop_i && (count_q != '0);
  assign n_push = {1'b0, push0_i} + {1'b0, push1_i};

  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wr_ptr_q] <= rec0_i;
    if (push1_i) mem_q[wr_ptr_q + AW'(1)] <= rec1_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + CW'(n_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/mips_trace_capture.sv
// Captures register writebacks and stores into a stamped trace FIFO.
// Record fields are 32 bits wide, so WORD_WIDTH is limited to 32.
module mips_trace_capture
  import mips_trace_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    capture_en,
  input  logic                    MEM_WB_RegWrite,
  input  logic [4:0]              MEM_WB_RegisterRd,
  input  logic [WORD_WIDTH-1:0]   RegWriteData,
  input  logic                    EX_MEM_MemWrite,
  input  logic [WORD_WIDTH-1:0]   EX_MEM_ALU_result,
  input  logic [WORD_WIDTH-1:0]   EX_MEM_MemWriteData,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [1:0]              trace_kind,
  output logic [WORD_WIDTH-1:0]   trace_addr,
  output logic [WORD_WIDTH-1:0]   trace_data,
  output logic [STAMP_WIDTH-1:0]  trace_stamp,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             overflow_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [STAMP_WIDTH-1:0] cycle_q, cycle_d;
  logic [15:0]            ovf_q, ovf_d;
  logic [16:0]            ovf_sum;
  logic                   reg_ev, mem_ev;
  trace_rec_t             reg_rec, mem_rec, rec0, rec1, head;
  logic                   ev0, ev1, push0, push1, fifo_valid;
  logic [CW-1:0]          count, free;
  logic [1:0]             dropped;

  assign reg_ev = capture_en && MEM_WB_RegWrite && (MEM_WB_RegisterRd != 5'd0);
  assign mem_ev = capture_en && EX_MEM_MemWrite;

  always_comb begin
    reg_rec       = '0;
    reg_rec.kind  = REG_WB;
    reg_rec.addr  = REC_WORD_WIDTH'(MEM_WB_RegisterRd);
    reg_rec.data  = REC_WORD_WIDTH'(RegWriteData);
    reg_rec.stamp = cycle_q;
    mem_rec       = '0;
    mem_rec.kind  = MEM_WR;
    mem_rec.addr  = REC_WORD_WIDTH'(EX_MEM_ALU_result);
    mem_rec.data  = REC_WORD_WIDTH'(EX_MEM_MemWriteData);
    mem_rec.stamp = cycle_q;
  end

  // Compact events so the first one always uses push0; free space ignores this cycle's pop
  assign ev0   = reg_ev || mem_ev;
  assign ev1   = reg_ev && mem_ev;
  assign rec0  = reg_ev ? reg_rec : mem_rec;
  assign rec1  = mem_rec;
  assign free  = CW'(DEPTH) - count;
  assign push0 = ev0 && (free != '0);
  assign push1 = ev1 && (free >= CW'(2));

  assign dropped = {1'b0, ev0 && !push0} + {1'b0, ev1 && !push1};
  assign ovf_sum = {1'b0, ovf_q} + 17'(dropped);
  assign ovf_d   = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
  assign cycle_d = cycle_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      ovf_q   <= '0;
    end else begin
      cycle_q <= cycle_d;
      ovf_q   <= ovf_d;
    end
  end

  trace_fifo_dual_push #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push0_i (push0),
    .rec0_i  (rec0),
    .push1_i (push1),
    .rec1_i  (rec1),
    .pop_i   (trace_ready),
    .head_o  (head),
    .valid_o (fifo_valid),
    .count_o (count)
  );

  // Head fields are forced to zero when empty so reset clears them without a clock
  assign trace_valid  = fifo_valid;
  assign trace_kind   = fifo_valid ? head.kind : 2'b00;
  assign trace_addr   = fifo_valid ? head.addr[WORD_WIDTH-1:0] : '0;
  assign trace_data   = fifo_valid ? head.data[WORD_WIDTH-1:0] : '0;
  assign trace_stamp  = fifo_valid ? head.stamp : '0;
  assign fifo_count   = count;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_mips_trace_capture.sv
// Self-checking bench for mips_trace_capture against a queue-based reference model.
module tb_mips_trace_capture;

  localparam int DEPTH = 16;
  localparam int WW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          capture_en = 1'b0;
  logic          MEM_WB_RegWrite = 1'b0;
  logic [4:0]    MEM_WB_RegisterRd = '0;
  logic [WW-1:0] RegWriteData = '0;
  logic          EX_MEM_MemWrite = 1'b0;
  logic [WW-1:0] EX_MEM_ALU_result = '0;
  logic [WW-1:0] EX_MEM_MemWriteData = '0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [1:0]    trace_kind;
  logic [WW-1:0] trace_addr;
  logic [WW-1:0] trace_data;
  logic [15:0]   trace_stamp;
  logic [4:0]    fifo_count;
  logic [15:0]   overflow_cnt;

  always #5 clk = ~clk;

  mips_trace_capture #(.DEPTH(DEPTH), .WORD_WIDTH(WW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .capture_en          (capture_en),
    .MEM_WB_RegWrite     (MEM_WB_RegWrite),
    .MEM_WB_RegisterRd   (MEM_WB_RegisterRd),
    .RegWriteData        (RegWriteData),
    .EX_MEM_MemWrite     (EX_MEM_MemWrite),
    .EX_MEM_ALU_result   (EX_MEM_ALU_result),
    .EX_MEM_MemWriteData (EX_MEM_MemWriteData),
    .trace_valid         (trace_valid),
    .trace_ready         (trace_ready),
    .trace_kind          (trace_kind),
    .trace_addr          (trace_addr),
    .trace_data          (trace_data),
    .trace_stamp         (trace_stamp),
    .fifo_count          (fifo_count),
    .overflow_cnt        (overflow_cnt)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] stamp;
  } rec_t;

  rec_t        mq[$];
  logic [15:0] cyc;
  int          ovf;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic idle_inputs();
    MEM_WB_RegWrite     = 1'b0;
    MEM_WB_RegisterRd   = '0;
    RegWriteData        = '0;
    EX_MEM_MemWrite     = 1'b0;
    EX_MEM_ALU_result   = '0;
    EX_MEM_MemWriteData = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    cyc = '0;
    ovf = 0;
  endtask

  // One clock edge: the model sees exactly what the DUT samples, then outputs are sampled 1 ns later.
  task automatic tick();
    rec_t ev[$];
    rec_t r;
    bit   pop;
    int   free;
    pop  = (mq.size() > 0) && trace_ready;
    free = DEPTH - mq.size();
    if (capture_en && MEM_WB_RegWrite && MEM_WB_RegisterRd != 5'd0) begin
      r.kind = 2'b00; r.addr = 32'(MEM_WB_RegisterRd); r.data = RegWriteData; r.stamp = cyc;
      ev.push_back(r);
    end
    if (capture_en && EX_MEM_MemWrite) begin
      r.kind = 2'b01; r.addr = EX_MEM_ALU_result; r.data = EX_MEM_MemWriteData; r.stamp = cyc;
      ev.push_back(r);
    end
    if (pop) void'(mq.pop_front());
    for (int i = 0; i < ev.size(); i++) begin
      if (i < free) mq.push_back(ev[i]);
      else if (ovf < 65535) ovf++;
    end
    cyc = cyc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (trace_valid !== 1'b0 || fifo_count !== 5'd0 || overflow_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b count=%0d ovf=%0d required 0/0/0", trace_valid, fifo_count, overflow_cnt);
    end
    n_checks++;
    if (trace_kind !== 2'd0 || trace_addr !== '0 || trace_data !== '0 || trace_stamp !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: kind=%h addr=%h data=%h stamp=%h required all zero", trace_kind, trace_addr, trace_data, trace_stamp);
    end
    // events presented while reset is held must never be captured
    capture_en = 1'b1;
    MEM_WB_RegWrite = 1'b1; MEM_WB_RegisterRd = 5'd7; RegWriteData = 32'h1234;
    EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h10; EX_MEM_MemWriteData = 32'h99;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_capture: count=%0d valid=%b required 0/0", fifo_count, trace_valid);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_store();
    apply_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h40; EX_MEM_MemWriteData = 32'hDEADBEEF;
    tick();
    idle_inputs();
    n_checks++;
    if (trace_valid !== 1'b1 || trace_kind !== 2'b01 || trace_addr !== 32'h40 ||
        trace_data !== 32'hDEADBEEF || trace_stamp !== 16'd5 || fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL single_store: valid=%b kind=%h addr=%h data=%h stamp=%0d count=%0d required 1/01/40/deadbeef/5/1",
               trace_valid, trace_kind, trace_addr, trace_data, trace_stamp, fifo_count);
    end
    tick();
    n_checks++;
    if (trace_valid !== 1'b0 || fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL single_store_pop: valid=%b count=%0d required 0/0", trace_valid, fifo_count);
    end
  endtask

  task automatic test_dual_event();
    logic [15:0] exp_stamp;
    trace_ready = 1'b0;
    MEM_WB_RegWrite = 1'b1; MEM_WB_RegisterRd = 5'd8; RegWriteData = 32'h11;
    EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h4; EX_MEM_MemWriteData = 32'h22;
    exp_stamp = cyc;
    tick();
    idle_inputs();
    tick();
    n_checks++;
    if (fifo_count !== 5'd2 || trace_kind !== 2'b00 || trace_addr !== 32'd8 ||
        trace_data !== 32'h11 || trace_stamp !== exp_stamp) begin
      n_fail++;
      $display("FAIL dual_first: count=%0d kind=%h addr=%h data=%h stamp=%0d required 2/00/8/11/%0d",
               fifo_count, trace_kind, trace_addr, trace_data, trace_stamp, exp_stamp);
    end
    trace_ready = 1'b1;
    tick();
    n_checks++;
    if (fifo_count !== 5'd1 || trace_kind !== 2'b01 || trace_addr !== 32'h4 ||
        trace_data !== 32'h22 || trace_stamp !== exp_stamp) begin
      n_fail++;
      $display("FAIL dual_second: count=%0d kind=%h addr=%h data=%h stamp=%0d required 1/01/4/22/%0d",
               fifo_count, trace_kind, trace_addr, trace_data, trace_stamp, exp_stamp);
    end
    tick();
    n_checks++;
    if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL dual_drain: count=%0d valid=%b required 0/0", fifo_count, trace_valid);
    end
  endtask

  task automatic test_rd_zero();
    trace_ready = 1'b0;
    EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h8; EX_MEM_MemWriteData = 32'h5;
    tick();
    idle_inputs();
    MEM_WB_RegWrite = 1'b1; MEM_WB_RegisterRd = 5'd0; RegWriteData = 32'hFFFFFFFF;
    tick();
    idle_inputs();
    n_checks++;
    if (fifo_count !== 5'd1 || trace_kind !== 2'b01 || trace_addr !== 32'h8) begin
      n_fail++;
      $display("FAIL rd_zero: count=%0d kind=%h addr=%h required 1/01/8", fifo_count, trace_kind, trace_addr);
    end
    // capture disabled: new events ignored, stored entry still drains
    capture_en = 1'b0;
    trace_ready = 1'b1;
    MEM_WB_RegWrite = 1'b1; MEM_WB_RegisterRd = 5'd9; EX_MEM_MemWrite = 1'b1;
    tick();
    idle_inputs();
    capture_en = 1'b1;
    n_checks++;
    if (fifo_count !== 5'd0 || trace_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_disabled: count=%0d valid=%b required 0/0", fifo_count, trace_valid);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h100 + 32'(4 * i); EX_MEM_MemWriteData = 32'hA000 + 32'(i);
      tick();
    end
    idle_inputs();
    n_checks++;
    if (fifo_count !== 5'd16 || overflow_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL overflow_count: count=%0d ovf=%0d required 16/2", fifo_count, overflow_cnt);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (trace_valid !== 1'b1 || trace_addr !== 32'h100 + 32'(4 * i) || trace_data !== 32'hA000 + 32'(i)) begin
        n_fail++;
        $display("FAIL overflow_order[%0d]: valid=%b addr=%h data=%h required 1/%h/%h",
                 i, trace_valid, trace_addr, trace_data, 32'h100 + 32'(4 * i), 32'hA000 + 32'(i));
      end
      tick();
    end
    n_checks++;
    if (fifo_count !== 5'd0 || overflow_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL overflow_drain: count=%0d ovf=%0d required 0/2", fifo_count, overflow_cnt);
    end
  endtask

  task automatic test_full_dual_pop();
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'(i); EX_MEM_MemWriteData = 32'(i + 100);
      tick();
    end
    MEM_WB_RegWrite = 1'b1; MEM_WB_RegisterRd = 5'd3; RegWriteData = 32'h33;
    EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'h80; EX_MEM_MemWriteData = 32'h44;
    trace_ready = 1'b1;
    tick();
    idle_inputs();
    trace_ready = 1'b0;
    n_checks++;
    if (fifo_count !== 5'd15 || overflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL full_dual_pop: count=%0d ovf=%0d required 15/1", fifo_count, overflow_cnt);
    end
    trace_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      n_checks++;
      if (trace_valid !== 1'b1 || trace_kind !== mq[0].kind || trace_addr !== mq[0].addr ||
          trace_data !== mq[0].data || trace_stamp !== mq[0].stamp) begin
        n_fail++;
        $display("FAIL full_dual_drain[%0d]: kind=%h addr=%h data=%h stamp=%0d required %h/%h/%h/%0d",
                 i, trace_kind, trace_addr, trace_data, trace_stamp, mq[0].kind, mq[0].addr, mq[0].data, mq[0].stamp);
      end
      if (i == 14) begin
        n_checks++;
        if (trace_kind !== 2'b00 || trace_addr !== 32'd3 || trace_data !== 32'h33) begin
          n_fail++;
          $display("FAIL full_dual_last: kind=%h addr=%h data=%h required 00/3/33", trace_kind, trace_addr, trace_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      EX_MEM_MemWrite = 1'b1; EX_MEM_ALU_result = 32'(i * 8); EX_MEM_MemWriteData = 32'(i);
      tick();
    end
    idle_inputs();
    trace_ready = 1'b1;
    n_checks++;
    if (fifo_count !== 5'd5 || overflow_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mid_drain_setup: count=%0d ovf=%0d required 5/1", fifo_count, overflow_cnt);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (trace_valid !== 1'b0 || fifo_count !== 5'd0 || overflow_cnt !== 16'd0 ||
        trace_addr !== '0 || trace_data !== '0 || trace_stamp !== '0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: valid=%b count=%0d ovf=%0d addr=%h data=%h stamp=%0d required all zero",
               trace_valid, fifo_count, overflow_cnt, trace_addr, trace_data, trace_stamp);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    trace_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      capture_en          = ($urandom_range(0, 3) != 0);
      MEM_WB_RegWrite     = $urandom_range(0, 1);
      MEM_WB_RegisterRd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      RegWriteData        = $urandom;
      EX_MEM_MemWrite     = $urandom_range(0, 1);
      EX_MEM_ALU_result   = $urandom;
      EX_MEM_MemWriteData = $urandom;
      trace_ready         = ((n / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
      tick();
      n_checks++;
      if (fifo_count !== 5'(mq.size()) || overflow_cnt !== 16'(ovf) || trace_valid !== (mq.size() > 0)) begin
        n_fail++;
        $display("FAIL random_state[%0d]: count=%0d ovf=%0d valid=%b required %0d/%0d/%b",
                 n, fifo_count, overflow_cnt, trace_valid, mq.size(), ovf, mq.size() > 0);
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (trace_kind !== mq[0].kind || trace_addr !== mq[0].addr ||
            trace_data !== mq[0].data || trace_stamp !== mq[0].stamp) begin
          n_fail++;
          $display("FAIL random_head[%0d]: kind=%h addr=%h data=%h stamp=%0d required %h/%h/%h/%0d",
                   n, trace_kind, trace_addr, trace_data, trace_stamp, mq[0].kind, mq[0].addr, mq[0].data, mq[0].stamp);
        end
      end
    end
    idle_inputs();
    capture_en = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_store();
    test_dual_event();
    test_rd_zero();
    test_overflow();
    test_full_dual_pop();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
